dmem_dump_responder: RTL and testbench
======================================

Name: dmem_dump_responder

Overview:
- Data-memory responder for the processor's DM write/read interface (DM_addr, DM_writeData, DM_writeEnable, read data).
- Holds DEPTH doublewords and serves the core's combinational reads and clocked writes.
- On the `dump` request, a readout FSM streams every memory word out over a valid/ready port so the bench can check final memory state.
- Sits beside the core in the top-level; the core keeps the initiator role.

Parameters:
- N, 64, data and address width in bits.
- DEPTH, 64, number of N-bit words; must be a power of 2.
- AW, $clog2(DEPTH), word-index width.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- DM_writeEnable  in  1  write strobe from core.
- DM_readEnable  in  1  read strobe from core.
- DM_addr  in  N  byte address from core.
- DM_writeData  in  N  write data from core.
- DM_readData  out  N  read data to core.
- dump  in  1  level request to start readout.
- dump_valid  out  1  dump_data/dump_idx are valid.
- dump_ready  in  1  consumer accepts the current word.
- dump_idx  out  AW  word index of dump_data.
- dump_data  out  N  streamed memory word.
- dump_done  out  1  readout finished; held high until dump falls.
- err_misalign  out  1  sticky flag: access with DM_addr[2:0] != 0.
- err_oob  out  1  sticky flag: access with DM_addr >= DEPTH*8.

Behaviour:
- Reset (reset==0, asynchronous):
  - mem[i] = i for all i.
  - FSM = IDLE.
  - dump_valid=0, dump_done=0, dump_idx=0, dump_data=0, err flags=0.
  - The prior-`dump` register is cleared to 0.
- Address decode:
  - word index = DM_addr[AW+2:3].
  - An access is legal iff DM_addr[2:0]==0 and DM_addr[N-1:AW+3]==0.
- Read path:
  - Combinational, zero latency: DM_readData = mem[idx] when DM_readEnable and legal, else 0.
  - Write-then-read of the same index returns the new value from the next cycle onward.
- Write path:
  - On a rising edge with DM_writeEnable and a legal address, mem[idx] <= DM_writeData.
  - An illegal write is dropped and sets the matching sticky flag (misalign takes priority when both apply).
  - An illegal read returns 0 and sets the sticky flag.
  - Flags clear only on reset.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE -> LOAD on the rising edge of `dump` (dump==1 and the prior registered value was 0); ptr <= 0.
  - LOAD: dump_data <= mem[ptr], dump_idx <= ptr, dump_valid <= 1; -> SEND. One cycle, so there is 1 bubble cycle per word.
  - SEND: data, idx and valid are held stable while dump_ready==0.
    - On dump_valid && dump_ready: dump_valid <= 0.
    - If ptr == DEPTH-1 -> DONE; else ptr <= ptr+1 -> LOAD.
  - DONE: dump_done=1. -> IDLE when dump==0, and dump_done clears in that same transition.
  - If `dump` falls during LOAD/SEND, the readout still completes all DEPTH words; DONE is then left on the next cycle.
  - A full readout takes 2*DEPTH cycles plus stall cycles.
- Writes during a dump are still performed.
  - A word already captured in dump_data is not updated.
  - A write to index k in the same cycle as LOAD of k: the stream gets the pre-write value.
- ptr wraps never: the terminal check happens at DEPTH-1.
- Reset asserted mid-dump aborts the readout immediately: dump_valid drops asynchronously and the FSM returns to IDLE.

Decomposition:
- Shared package dmem_pkg:
  - FSM enum dump_state_t {IDLE, LOAD, SEND, DONE}.
  - Constant WORD_BYTES=8.
  - Function is_legal_addr().
- Sub-module dmem_array:
  - Storage with async-reset init.
  - Combinational read port plus a second read port for the dump FSM.
  - Single clocked write port.
- The top level holds the decode, the flags and the FSM.

Test Plan:
1. Reset, then DM_readEnable with DM_addr=0x18 -> DM_readData=3, all flags 0, dump_valid=0.
2. Write 0xDEADBEEF to DM_addr=0x20, then read 0x20 the next cycle -> 0xDEADBEEF; read 0x28 -> 5.
3. Write to DM_addr=0x21 -> mem unchanged, err_misalign=1. Read DM_addr=0x200 (DEPTH=64) -> DM_readData=0, err_oob=1. Both flags stay high until reset.
4. Raise dump with dump_ready=1 -> 64 beats, idx 0..63, data=i except idx 4 = 0xDEADBEEF. dump_done rises after beat 63 and falls one cycle after dump=0.
5. Dump with dump_ready toggled pseudo-randomly -> no beat lost or duplicated; data and idx stay stable while stalled. Write idx 63 while ptr=10 -> the stream shows the new value at idx 63.
6. Pull reset low at ptr=30 -> dump_valid=0 immediately and mem restored to mem[i]=i. A new rising edge of `dump` restarts from idx 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory dump responder.
//   dump_state_t  : readout FSM states
//   WORD_BYTES    : bytes per doubleword
//   OFS_W         : byte-offset bits within a word
//   is_legal_addr : aligned and inside the populated word range
package dmem_pkg;

   localparam int unsigned WORD_BYTES = 8;
   localparam int unsigned OFS_W      = $clog2(WORD_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dump_state_t;

   // Legal iff the byte offset is zero and no bits above the word index are set.
   function automatic logic is_legal_addr(input logic [63:0] addr, input int unsigned aw);
      logic [63:0] w_upper;
      w_upper = addr >> (aw + OFS_W);
      return (addr[OFS_W-1:0] == '0) && (w_upper == 64'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: reset loads mem[i] = i, one clocked write port,
// two combinational read ports (core read path and dump readout).
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_we, i_waddr, i_wdata: write port
//   i_raddr_a / o_rdata_a : core read port
//   i_raddr_b / o_rdata_b : dump read port
module dmem_array #(
   parameter int unsigned N     = 64,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [N-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   output logic [N-1:0]  o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [N-1:0]  o_rdata_b
);

   logic [N-1:0] r_mem [DEPTH];

   // Storage with identity initialisation on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= N'(i);
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/dmem_dump_responder.sv
// Data-memory responder for the core's DM interface, with a readout FSM that
// streams every word over a valid/ready port on a rising edge of dump.
//   CLOCK_50, reset              : clock, async active-low reset
//   DM_writeEnable/DM_readEnable : core strobes
//   DM_addr, DM_writeData        : byte address and write data
//   DM_readData                  : combinational read data (0 if illegal/idle)
//   dump, dump_ready             : readout request (level) and consumer ready
//   dump_valid, dump_idx,
//   dump_data, dump_done         : readout stream and completion
//   err_misalign, err_oob        : sticky illegal-access flags
module dmem_dump_responder
   import dmem_pkg::*;
#(
   parameter int unsigned N     = 64,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          DM_writeEnable,
   input  logic          DM_readEnable,
   input  logic [N-1:0]  DM_addr,
   input  logic [N-1:0]  DM_writeData,
   output logic [N-1:0]  DM_readData,
   input  logic          dump,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_idx,
   output logic [N-1:0]  dump_data,
   output logic          dump_done,
   output logic          err_misalign,
   output logic          err_oob
);

   logic [AW-1:0] w_idx;
   logic          w_legal;
   logic          w_misalign;
   logic          w_access;
   logic          w_we;
   logic [N-1:0]  w_rdata_a;
   logic [N-1:0]  w_rdata_b;

   dump_state_t   r_state;
   logic [AW-1:0] r_ptr;
   logic          r_dump_q;

   // Address decode.
   assign w_idx      = DM_addr[AW+OFS_W-1:OFS_W];
   assign w_misalign = (DM_addr[OFS_W-1:0] != '0);
   assign w_legal    = is_legal_addr(64'(DM_addr), AW);
   assign w_access   = DM_writeEnable | DM_readEnable;
   assign w_we       = DM_writeEnable & w_legal;

   dmem_array #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .i_clk     (CLOCK_50),
      .i_rst_n   (reset),
      .i_we      (w_we),
      .i_waddr   (w_idx),
      .i_wdata   (DM_writeData),
      .i_raddr_a (w_idx),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (r_ptr),
      .o_rdata_b (w_rdata_b)
   );

   assign DM_readData = (DM_readEnable && w_legal) ? w_rdata_a : '0;

   // Sticky error flags; misalignment wins when both conditions hold.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         err_misalign <= 1'b0;
         err_oob      <= 1'b0;
      end else if (w_access && !w_legal) begin
         if (w_misalign) err_misalign <= 1'b1;
         else            err_oob      <= 1'b1;
      end
   end

   // Readout FSM. LOAD captures mem[ptr] a cycle before it is offered, so a
   // same-cycle write to that word is seen only by later readouts.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_dump_q   <= 1'b0;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
      end else begin
         r_dump_q <= dump;
         case (r_state)
            IDLE: begin
               if (dump && !r_dump_q) begin
                  r_ptr   <= '0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               dump_data  <= w_rdata_b;
               dump_idx   <= r_ptr;
               dump_valid <= 1'b1;
               r_state    <= SEND;
            end
            SEND: begin
               // dump_valid is always high here, so ready alone completes the beat.
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  if (r_ptr == AW'(DEPTH - 1)) begin
                     dump_done <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_ptr   <= r_ptr + AW'(1);
                     r_state <= LOAD;
                  end
               end
            end
            DONE: begin
               if (!dump) begin
                  dump_done <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Scoreboard bench for dmem_dump_responder: a reference memory model predicts
// reads, flags and the dump stream; a negedge monitor checks every beat.
module tb_dmem_dump_responder;

   localparam int unsigned N     = 64;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b0;
   logic          DM_writeEnable = 1'b0;
   logic          DM_readEnable = 1'b0;
   logic [N-1:0]  DM_addr = '0;
   logic [N-1:0]  DM_writeData = '0;
   logic [N-1:0]  DM_readData;
   logic          dump = 1'b0;
   logic          dump_valid;
   logic          dump_ready = 1'b1;
   logic [AW-1:0] dump_idx;
   logic [N-1:0]  dump_data;
   logic          dump_done;
   logic          err_misalign;
   logic          err_oob;

   dmem_dump_responder #(.N(N), .DEPTH(DEPTH)) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .DM_writeEnable (DM_writeEnable),
      .DM_readEnable  (DM_readEnable),
      .DM_addr        (DM_addr),
      .DM_writeData   (DM_writeData),
      .DM_readData    (DM_readData),
      .dump           (dump),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_idx       (dump_idx),
      .dump_data      (dump_data),
      .dump_done      (dump_done),
      .err_misalign   (err_misalign),
      .err_oob        (err_oob)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int          idx;
      logic [63:0] data;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] model [DEPTH];
   logic        m_mis = 1'b0;
   logic        m_oob = 1'b0;
   beat_t       exp_q[$];
   int          beats_total = 0;
   bit          rdy_rand = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit legal(input logic [63:0] a);
      return (a % 64'd8 == 64'd0) && (a < 64'(DEPTH * 8));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = 64'(i);
      m_mis = 1'b0;
      m_oob = 1'b0;
   endtask

   task automatic model_flag(input logic [63:0] a);
      if (!legal(a)) begin
         if (a % 64'd8 != 64'd0) m_mis = 1'b1;
         else                    m_oob = 1'b1;
      end
   endtask

   task automatic slot();
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic check_flags();
      chk("err_misalign", 64'(err_misalign), 64'(m_mis));
      chk("err_oob", 64'(err_oob), 64'(m_oob));
   endtask

   task automatic do_read(input logic [63:0] a);
      logic [63:0] exp;
      DM_readEnable = 1'b1;
      DM_addr       = a;
      #1;
      exp = legal(a) ? model[a / 64'd8] : 64'd0;
      chk($sformatf("read@0x%0h", a), DM_readData, exp);
      slot();
      model_flag(a);
      DM_readEnable = 1'b0;
      check_flags();
   endtask

   task automatic do_write(input logic [63:0] a, input logic [63:0] d);
      DM_writeEnable = 1'b1;
      DM_addr        = a;
      DM_writeData   = d;
      slot();
      if (legal(a)) model[a / 64'd8] = d;
      model_flag(a);
      DM_writeEnable = 1'b0;
   endtask

   task automatic load_expected();
      exp_q.delete();
      for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back('{i, model[i]});
   endtask

   // Full readout; optionally writes a fresh value to the last word once
   // wr_at beats have been seen, long before that word is loaded.
   task automatic run_dump(input bit rnd, input int wr_at);
      int          base;
      bit          wrote;
      logic [63:0] newv;
      load_expected();
      base     = beats_total;
      rdy_rand = rnd;
      wrote    = 1'b0;
      dump     = 1'b1;
      for (int c = 0; c < 4000 && (beats_total - base) < int'(DEPTH); c++) begin
         if (!wrote && wr_at >= 0 && (beats_total - base) >= wr_at) begin
            newv = {$urandom, $urandom};
            do_write(64'((DEPTH - 1) * 8), newv);
            foreach (exp_q[j]) if (exp_q[j].idx == int'(DEPTH) - 1) exp_q[j].data = newv;
            wrote = 1'b1;
         end else begin
            slot();
         end
      end
      chk("beat_count", 64'(beats_total - base), 64'(DEPTH));
      for (int c = 0; c < 10 && !dump_done; c++) slot();
      chk("done_rise", 64'(dump_done), 64'd1);
      chk("valid_after_done", 64'(dump_valid), 64'd0);
      slot();
      slot();
      chk("done_hold", 64'(dump_done), 64'd1);
      dump = 1'b0;
      slot();
      chk("done_fall", 64'(dump_done), 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      rdy_rand = 1'b0;
   endtask

   // Consumer ready: always 1 or a coin flip each cycle.
   initial begin
      forever begin
         @(posedge CLOCK_50);
         #2;
         dump_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: checks hold-while-stalled and scores each accepted beat.
   bit          prev_stall = 1'b0;
   logic [AW-1:0] prev_idx;
   logic [63:0] prev_data;
   always @(negedge CLOCK_50) begin
      beat_t b;
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(dump_valid), 64'd1);
            chk("stall_idx", 64'(dump_idx), 64'(prev_idx));
            chk("stall_data", dump_data, prev_data);
         end
         if (dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got idx %0d with empty queue", dump_idx);
            end else begin
               b = exp_q.pop_front();
               chk("beat_idx", 64'(dump_idx), 64'(b.idx));
               chk($sformatf("beat_data[%0d]", b.idx), dump_data, b.data);
            end
            beats_total++;
         end
         prev_stall = dump_valid && !dump_ready;
         prev_idx   = dump_idx;
         prev_data  = dump_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a;
      model_reset();
      #35 reset = 1'b1;
      slot();

      // Reset state and first read.
      chk("rst_valid", 64'(dump_valid), 64'd0);
      chk("rst_done", 64'(dump_done), 64'd0);
      chk("rst_idx", 64'(dump_idx), 64'd0);
      chk("rst_data", dump_data, 64'd0);
      check_flags();
      DM_addr = 64'h18;
      #1;
      chk("read_disabled", DM_readData, 64'd0);
      do_read(64'h18);

      // Write then read back.
      do_write(64'h20, 64'hDEAD_BEEF);
      do_read(64'h20);
      do_read(64'h28);

      // Illegal accesses.
      do_write(64'h21, 64'h1234);
      check_flags();
      do_read(64'h20);
      do_read(64'h200);
      do_read(64'h8);

      // Straight readout.
      run_dump(1'b0, -1);

      // Random legal/illegal traffic.
      for (int k = 0; k < 40; k++) begin
         a = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
         case ($urandom_range(0, 9))
            0: a = a + 64'($urandom_range(1, 7));
            1: a = a + 64'(DEPTH * 8) * 64'($urandom_range(1, 100));
            default: ;
         endcase
         if ($urandom_range(0, 1) == 1) do_write(a, {$urandom, $urandom});
         else                            do_read(a);
      end

      // Stalled readout with a write to the last word mid-stream.
      run_dump(1'b1, 10);
      do_read(64'((DEPTH - 1) * 8));

      // Reset during readout.
      load_expected();
      rdy_rand = 1'b1;
      a = 64'(beats_total);
      dump = 1'b1;
      for (int c = 0; c < 2000 && beats_total < int'(a) + 30; c++) slot();
      @(posedge CLOCK_50);
      #5;
      reset = 1'b0;
      #1;
      chk("abort_valid", 64'(dump_valid), 64'd0);
      chk("abort_done", 64'(dump_done), 64'd0);
      exp_q.delete();
      model_reset();
      dump     = 1'b0;
      rdy_rand = 1'b0;
      @(posedge CLOCK_50);
      #5;
      reset = 1'b1;
      slot();
      check_flags();
      do_read(64'h20);
      do_read(64'((DEPTH - 1) * 8));
      run_dump(1'b1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
